// File: rtl/sdram_pkg.sv
// Shared constants and types for the SDRAM port arbiter.
package sdram_pkg;
  localparam int SDRAM_AW = 24;
  localparam int SDRAM_DW = 16;
  localparam int NP_DEF   = 2;

  typedef logic [$clog2(NP_DEF)-1:0] port_id_t;
  typedef enum logic {IDLE, HOLD} lock_state_e;
endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester-side and controller-side buses of the SDRAM arbiter.
interface sdram_arbiter_if import sdram_pkg::*; #(
  parameter int NP = 2,
  parameter int AW = SDRAM_AW,
  parameter int DW = SDRAM_DW
);
  logic [NP-1:0]    p_req_valid;
  logic [NP-1:0]    p_req_write;
  logic [NP*AW-1:0] p_req_addr;
  logic [NP*DW-1:0] p_req_wdata;
  logic [NP*2-1:0]  p_req_byteenable;
  logic [NP-1:0]    p_req_ready;
  logic [NP-1:0]    p_rsp_valid;
  logic [DW-1:0]    p_rsp_rdata;
  logic             m_req_valid;
  logic             m_req_write;
  logic [AW-1:0]    m_req_addr;
  logic [DW-1:0]    m_req_wdata;
  logic [1:0]       m_req_byteenable;
  logic             m_req_ready;
  logic             m_rsp_valid;
  logic [DW-1:0]    m_rsp_rdata;

  modport slave (
    input  p_req_valid, p_req_write, p_req_addr, p_req_wdata, p_req_byteenable,
    output p_req_ready, p_rsp_valid, p_rsp_rdata,
    output m_req_valid, m_req_write, m_req_addr, m_req_wdata, m_req_byteenable,
    input  m_req_ready, m_rsp_valid, m_rsp_rdata
  );

  modport master (
    output p_req_valid, p_req_write, p_req_addr, p_req_wdata, p_req_byteenable,
    input  p_req_ready, p_rsp_valid, p_rsp_rdata,
    input  m_req_valid, m_req_write, m_req_addr, m_req_wdata, m_req_byteenable,
    output m_req_ready, m_rsp_valid, m_rsp_rdata
  );
endinterface

// File: rtl/sdram_arb_id_fifo.sv
// Small sync FIFO holding the issuing port ID of each outstanding read.
module sdram_arb_id_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           din_i,
  output logic [W-1:0]           head_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count_q says they are valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one sdram_controller port among NP requesters,
// with grant lock under back-pressure and in-order read-data routing.
module sdram_arbiter import sdram_pkg::*; #(
  parameter int NP       = 2,
  parameter int AW       = SDRAM_AW,
  parameter int DW       = SDRAM_DW,
  parameter int RD_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  sdram_arbiter_if.slave bus,
  output logic           err_unexp_rsp
);
  localparam int IDW = (NP > 1) ? $clog2(NP) : 1;
  localparam int CW  = $clog2(RD_DEPTH) + 1;

  lock_state_e    state_q, state_d;
  logic [IDW-1:0] lock_id_q, lock_id_d, rr_ptr_q, rr_ptr_d, gnt, head;
  logic           gnt_vld, xfer, push, pop, rd_full, err_q, err_d;
  logic [CW-1:0]  rd_count;
  logic [NP-1:0]  elig;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign rd_full = (rd_count == CW'(RD_DEPTH));
  assign elig    = bus.p_req_valid & (bus.p_req_write | {NP{!rd_full}});

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = rr_ptr_q;
    gnt_vld = 1'b0;
    if (state_q == HOLD) begin
      gnt     = lock_id_q;
      gnt_vld = bus.p_req_valid[lock_id_q];
    end else begin
      // Scan downwards so the closest eligible port to rr_ptr wins last.
      for (int k = NP-1; k >= 0; k--) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NP) idx = idx - NP;
        if (elig[idx]) begin
          gnt     = IDW'(idx);
          gnt_vld = 1'b1;
        end
      end
    end
  end

  assign xfer = gnt_vld & bus.m_req_ready;

  assign bus.m_req_valid      = gnt_vld;
  assign bus.m_req_write      = bus.p_req_write[gnt];
  assign bus.m_req_addr       = bus.p_req_addr[int'(gnt)*AW +: AW];
  assign bus.m_req_wdata      = bus.p_req_wdata[int'(gnt)*DW +: DW];
  assign bus.m_req_byteenable = bus.p_req_byteenable[int'(gnt)*2 +: 2];

  always_comb begin
    bus.p_req_ready = '0;
    if (gnt_vld) bus.p_req_ready[gnt] = bus.m_req_ready;
  end

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    case (state_q)
      IDLE: if (gnt_vld && !bus.m_req_ready) begin
        state_d   = HOLD;
        lock_id_d = gnt;
      end
      HOLD: if (!gnt_vld || xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (xfer) rr_ptr_d = (gnt == IDW'(NP-1)) ? '0 : gnt + 1'b1;
  end

  assign push  = xfer & ~bus.p_req_write[gnt];
  assign pop   = bus.m_rsp_valid & (rd_count != '0);
  assign err_d = err_q | (bus.m_rsp_valid & (rd_count == '0));

  always_comb begin
    bus.p_rsp_valid = '0;
    if (pop) bus.p_rsp_valid[head] = 1'b1;
  end

  assign bus.p_rsp_rdata = bus.m_rsp_rdata;
  assign err_unexp_rsp   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
      err_q     <= err_d;
    end
  end

  sdram_arb_id_fifo #(.W(IDW), .DEPTH(RD_DEPTH)) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (gnt),
    .head_o  (head),
    .count_o (rd_count)
  );
endmodule
